// File: rtl/spi_master_if.sv
// Bus between the on-chip requester and the SPI master, including the SPI pins.
interface spi_master_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] tx_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rx_data;
    logic             sclk;
    logic             cs;
    logic             mosi;
    logic             miso;

    modport master (
        input  start, tx_data, miso,
        output busy, done, rx_data, sclk, cs, mosi
    );

    modport slave (
        output start, tx_data, miso,
        input  busy, done, rx_data, sclk, cs, mosi
    );
endinterface

// File: rtl/spi_master.sv
// Single-word full-duplex SPI master: SCLK idles low, MOSI changes on the rise,
// MISO is sampled on the fall, MSB first. Every output is a register.
module spi_master #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic          clk,
    input  logic          rst,
    spi_master_if.master  bus
);
    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
    localparam int unsigned BIT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCLK_HIGH,
        SCLK_LOW,
        GAP
    } state_t;

    state_t             state, state_d;
    logic [DIV_W-1:0]   div, div_d;
    logic [BIT_W-1:0]   bit_cnt, bit_cnt_d;
    logic [WIDTH-1:0]   shift, shift_d;
    logic [WIDTH-1:0]   rx_shift, rx_shift_d;
    logic [WIDTH-1:0]   rx_data, rx_data_d;
    logic               cs, cs_d;
    logic               sclk, sclk_d;
    logic               mosi, mosi_d;
    logic               busy, busy_d;
    logic               done, done_d;
    logic               div_last;

    assign div_last = (div == DIV_W'(CLK_DIV - 1));

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            div      <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            cs       <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            div      <= div_d;
            bit_cnt  <= bit_cnt_d;
            shift    <= shift_d;
            rx_shift <= rx_shift_d;
            rx_data  <= rx_data_d;
            cs       <= cs_d;
            sclk     <= sclk_d;
            mosi     <= mosi_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    // Next state and next register values; outputs are computed one cycle early
    always_comb begin
        state_d    = state;
        div_d      = div;
        bit_cnt_d  = bit_cnt;
        shift_d    = shift;
        rx_shift_d = rx_shift;
        rx_data_d  = rx_data;
        cs_d       = cs;
        sclk_d     = sclk;
        mosi_d     = mosi;
        busy_d     = busy;
        done_d     = 1'b0;

        if (state != IDLE) begin
            div_d = div_last ? '0 : div + DIV_W'(1);
        end

        unique case (state)
            IDLE: begin
                if (bus.start && !busy) begin
                    state_d    = SETUP;
                    div_d      = '0;
                    bit_cnt_d  = '0;
                    shift_d    = bus.tx_data;
                    rx_shift_d = '0;
                    cs_d       = 1'b0;
                    busy_d     = 1'b1;
                    sclk_d     = 1'b0;
                    mosi_d     = 1'b0;
                end
            end
            SETUP: begin
                if (div_last) begin
                    state_d = SCLK_HIGH;
                    sclk_d  = 1'b1;
                    mosi_d  = shift[WIDTH-1];
                    shift_d = {shift[WIDTH-2:0], 1'b0};
                end
            end
            SCLK_HIGH: begin
                if (div_last) begin
                    state_d    = SCLK_LOW;
                    sclk_d     = 1'b0;
                    rx_shift_d = {rx_shift[WIDTH-2:0], bus.miso};
                    bit_cnt_d  = bit_cnt + BIT_W'(1);
                end
            end
            SCLK_LOW: begin
                // The last low half-period doubles as the CS hold time
                if (div_last) begin
                    if (bit_cnt == BIT_W'(WIDTH)) begin
                        state_d   = GAP;
                        cs_d      = 1'b1;
                        done_d    = 1'b1;
                        rx_data_d = rx_shift;
                        mosi_d    = 1'b0;
                    end else begin
                        state_d = SCLK_HIGH;
                        sclk_d  = 1'b1;
                        mosi_d  = shift[WIDTH-1];
                        shift_d = {shift[WIDTH-2:0], 1'b0};
                    end
                end
            end
            GAP: begin
                if (div_last) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cs      = cs;
    assign bus.sclk    = sclk;
    assign bus.mosi    = mosi;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.rx_data = rx_data;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master (WIDTH=8, CLK_DIV=2) with a small behavioural
// SPI slave that echoes the previously received byte, plus a MOSI->MISO loopback.
module tb_spi_master;
    logic clk = 1'b0;
    logic rst;
    logic loopback;

    spi_master_if #(.WIDTH(8)) bus ();

    spi_master #(.WIDTH(8), .CLK_DIV(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Slave model: drives MISO on SCLK rise, samples MOSI on SCLK fall
    logic [7:0] s_rx     = 8'h00;
    logic [7:0] s_reply  = 8'h00;
    logic [7:0] s_readed = 8'h00;
    logic       s_miso   = 1'b0;
    int         s_cnt    = 0;

    always @(negedge bus.cs) s_cnt = 0;
    always @(posedge bus.sclk) if (!bus.cs) s_miso = s_reply[3'(7 - s_cnt)];
    always @(negedge bus.sclk) if (!bus.cs) begin
        s_rx  = {s_rx[6:0], bus.mosi};
        s_cnt = s_cnt + 1;
    end
    always @(posedge bus.cs) if (!rst) begin
        s_readed = s_rx;
        s_reply  = s_rx;
    end

    assign bus.miso = loopback ? bus.mosi : s_miso;

    logic       cs_tr   [0:80];
    logic       sclk_tr [0:80];
    logic       busy_tr [0:80];
    logic       done_tr [0:80];
    logic [7:0] rx_tr   [0:80];
    int         rises;
    int         done_cnt;
    logic [7:0] mosi_bits;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue START at cycle t, then record cycles t+1..t+ncyc; hooks inject
    // extra START pulses, a TX_DATA change and a reset at given offsets.
    task automatic xfer(input logic [7:0] tx, input int ncyc, input bit hold,
                        input int p1, input int p2, input int chg_at, input int rst_at);
        rises     = 0;
        done_cnt  = 0;
        mosi_bits = 8'h00;
        sclk_tr[0] = bus.sclk;
        bus.tx_data = tx;
        bus.start   = 1'b1;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            cs_tr[n]   = bus.cs;
            sclk_tr[n] = bus.sclk;
            busy_tr[n] = bus.busy;
            done_tr[n] = bus.done;
            rx_tr[n]   = bus.rx_data;
            if (bus.done) done_cnt++;
            if (bus.sclk && !sclk_tr[n-1]) begin
                rises++;
                mosi_bits = {mosi_bits[6:0], bus.mosi};
            end
            bus.start = hold || (n == p1) || (n == p2) || (n == rst_at);
            if (n == chg_at) bus.tx_data = 8'hFF;
            rst = (n == rst_at);
        end
        bus.start = 1'b0;
        rst       = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        loopback    = 1'b0;
        bus.start   = 1'b0;
        bus.tx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_cs",   32'(bus.cs),      32'd1);
        check("rst_sclk", 32'(bus.sclk),    32'd0);
        check("rst_mosi", 32'(bus.mosi),    32'd0);
        check("rst_busy", 32'(bus.busy),    32'd0);
        check("rst_done", 32'(bus.done),    32'd0);
        check("rst_rx",   32'(bus.rx_data), 32'h00);
        rst = 1'b0;
        @(negedge clk);

        // Timing of one transfer against the slave, then a second for the echo
        xfer(8'hA5, 40, 1'b0, -1, -1, -1, -1);
        check("t1_cs_t1",     32'(cs_tr[1]),   32'd0);
        check("t1_busy_t1",   32'(busy_tr[1]), 32'd1);
        check("t1_sclk_t2",   32'(sclk_tr[2]), 32'd0);
        check("t1_sclk_t3",   32'(sclk_tr[3]), 32'd1);
        check("t1_sclk_t32",  32'(sclk_tr[32]), 32'd1);
        check("t1_sclk_t33",  32'(sclk_tr[33]), 32'd0);
        check("t1_cs_t34",    32'(cs_tr[34]),  32'd0);
        check("t1_cs_t35",    32'(cs_tr[35]),  32'd1);
        check("t1_done_t35",  32'(done_tr[35]), 32'd1);
        check("t1_done_cnt",  32'(done_cnt),   32'd1);
        check("t1_busy_t36",  32'(busy_tr[36]), 32'd1);
        check("t1_busy_t37",  32'(busy_tr[37]), 32'd0);
        check("t1_rises",     32'(rises),      32'd8);
        check("t1_mosi_bits", 32'(mosi_bits),  32'hA5);
        check("t2_slave_1",   32'(s_readed),   32'hA5);
        check("t2_rx_1",      32'(bus.rx_data), 32'h00);
        xfer(8'h3C, 40, 1'b0, -1, -1, -1, -1);
        check("t2_slave_2",   32'(s_readed),   32'h3C);
        check("t2_rx_2",      32'(bus.rx_data), 32'hA5);

        // Loopback of 0x81
        loopback = 1'b1;
        xfer(8'h81, 40, 1'b0, -1, -1, -1, -1);
        check("t3_rx",        32'(bus.rx_data), 32'h81);
        check("t3_mosi_bits", 32'(mosi_bits),   32'h81);

        // Ignored STARTs and a late TX_DATA change
        xfer(8'hC3, 45, 1'b0, 5, 20, 2, -1);
        check("t4_done_cnt",  32'(done_cnt),    32'd1);
        check("t4_rx",        32'(bus.rx_data), 32'hC3);
        check("t4_mosi_bits", 32'(mosi_bits),   32'hC3);

        // Reset together with START in the middle of a bit
        xfer(8'h33, 15, 1'b0, -1, -1, -1, 10);
        check("t5_cs",       32'(cs_tr[11]),   32'd1);
        check("t5_sclk",     32'(sclk_tr[11]), 32'd0);
        check("t5_busy",     32'(busy_tr[11]), 32'd0);
        check("t5_rx",       32'(rx_tr[11]),   32'h00);
        check("t5_done_cnt", 32'(done_cnt),    32'd0);
        xfer(8'h5A, 40, 1'b0, -1, -1, -1, -1);
        check("t5_rx_after", 32'(bus.rx_data), 32'h5A);
        check("t5_done_aft", 32'(done_cnt),    32'd1);

        // START held high: second transfer accepted in the first BUSY=0 cycle
        xfer(8'h96, 80, 1'b1, -1, -1, -1, -1);
        check("t6_cs_t36",   32'(cs_tr[36]),   32'd1);
        check("t6_cs_t37",   32'(cs_tr[37]),   32'd1);
        check("t6_busy_t37", 32'(busy_tr[37]), 32'd0);
        check("t6_cs_t38",   32'(cs_tr[38]),   32'd0);
        check("t6_busy_t38", 32'(busy_tr[38]), 32'd1);
        check("t6_done_t72", 32'(done_tr[72]), 32'd1);
        check("t6_rx_t72",   32'(rx_tr[72]),   32'h96);
        check("t6_done_cnt", 32'(done_cnt),    32'd2);
        repeat (45) @(negedge clk);
        check("t6_idle_busy", 32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
